// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide controller for the EX stage.
// Shift-add multiplier and restoring divider, one bit per cycle, sharing a
// single WIDTH+1-bit adder/subtractor.
// Optional macro MULDIV_EARLY_OUT_EN: multiply with a zero operand finishes from PREP.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       fn_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] md_q;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0] hi_q;   // product high half or remainder
    logic [WIDTH-1:0] lo_q;   // multiplier/product low half or quotient
    logic [CNT_W-1:0] cnt_q;

    logic             is_div, a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf, mul_zero, special;
    logic [WIDTH-1:0] special_val;
    logic [AW-1:0]    rem_sh, add_x, add_y, add_s;
    logic             sub;
    logic [PW-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix, fix_val;

    // Operand sign handling and special-case detection from the latched op.
    always_comb begin
        is_div   = fn_q[2];
        a_signed = (fn_q == F_MULH) || (fn_q == F_MULHSU) || (fn_q == F_DIV) || (fn_q == F_REM);
        b_signed = (fn_q == F_MULH) || (fn_q == F_DIV) || (fn_q == F_REM);
        a_neg    = a_signed & a_q[WIDTH-1];
        b_neg    = b_signed & b_q[WIDTH-1];
        a_mag    = a_neg ? (~a_q + WIDTH'(1)) : a_q;
        b_mag    = b_neg ? (~b_q + WIDTH'(1)) : b_q;
        div_zero = is_div && (b_q == '0);
        div_ovf  = ((fn_q == F_DIV) || (fn_q == F_REM)) &&
                   (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
`ifdef MULDIV_EARLY_OUT_EN
        mul_zero = !is_div && ((a_q == '0) || (b_q == '0));
`else
        mul_zero = 1'b0;
`endif
        special  = div_zero || div_ovf || mul_zero;
        if (div_zero) begin
            special_val = fn_q[1] ? a_q : '1;
        end else if (div_ovf) begin
            special_val = fn_q[1] ? '0 : a_q;
        end else begin
            special_val = '0;
        end
    end

    // Shared adder: add (multiply step) or trial-subtract (divide step).
    always_comb begin
        sub    = is_div;
        rem_sh = {hi_q, lo_q[WIDTH-1]};
        add_x  = is_div ? rem_sh : {1'b0, hi_q};
        add_y  = (is_div || lo_q[0]) ? {1'b0, md_q} : '0;
        add_s  = add_x + (add_y ^ {AW{sub}}) + AW'(sub);
    end

    // Sign correction and result selection.
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = (a_neg ^ b_neg) ? (~prod + PW'(1)) : prod;
        q_fix    = (a_neg ^ b_neg) ? (~lo_q + WIDTH'(1)) : lo_q;
        r_fix    = a_neg ? (~hi_q + WIDTH'(1)) : hi_q;
        case (fn_q)
            F_MUL:                      fix_val = prod_fix[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fix_val = prod_fix[PW-1:WIDTH];
            F_DIV, F_DIVU:              fix_val = q_fix;
            default:                    fix_val = r_fix;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control outputs.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = start;
                if (start && !flush) state_d = S_PREP;
            end
            S_PREP: begin
                stall = 1'b1;
                if (flush)        state_d = S_IDLE;
                else if (special) state_d = S_DONE;
                else              state_d = S_ITER;
            end
            S_ITER: begin
                stall = 1'b1;
                if (flush)                                state_d = S_IDLE;
                else if (cnt_q == CNT_W'(WIDTH - 1))      state_d = S_FIX;
            end
            S_FIX: begin
                stall   = 1'b1;
                state_d = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: operand latch, iteration, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fn_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            md_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            result <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        fn_q <= funct3;
                        a_q  <= op_a;
                        b_q  <= op_b;
                    end
                end
                S_PREP: begin
                    cnt_q <= '0;
                    hi_q  <= '0;
                    md_q  <= is_div ? b_mag : a_mag;
                    lo_q  <= is_div ? a_mag : b_mag;
                    if (special && !flush) result <= special_val;
                end
                S_ITER: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_div) begin
                        hi_q <= add_s[WIDTH] ? rem_sh[WIDTH-1:0] : add_s[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], ~add_s[WIDTH]};
                    end else begin
                        hi_q <= add_s[WIDTH:1];
                        lo_q <= {add_s[0], lo_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!flush) result <= fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (WIDTH=32) with an expected-result queue.
module tb_muldiv_sequencer;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 35;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          flush = 1'b0;
    logic          busy, stall, done;
    logic [W-1:0]  result;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble the operand inputs afterwards, wait for done.
    task automatic run_op(input string tag, input logic [2:0] fn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input int exp_lat, input bit poke_done);
        exp_t e;
        int   k;
        e.res = exp_res;
        e.lat = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        funct3 = fn; op_a = a; op_b = b; start = 1'b1;
        #1 check({tag, "_stall_start"}, W'(stall), W'(1));
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
        k = 1;
        while (done !== 1'b1 && k < 100) begin
            check({tag, "_stall_busy"}, W'({stall, busy}), W'(2'b11));
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        check({tag, "_done"}, W'(done), W'(1));
        check({tag, "_latency"}, W'(k), W'(e.lat));
        check({tag, "_result"}, result, e.res);
        check({tag, "_stall_done"}, W'({stall, busy}), W'(2'b01));
        if (poke_done) begin
            funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_after"}, W'({done, busy}), W'(2'b00));
        check({tag, "_result_held"}, result, e.res);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [W-1:0] prior;
        int           done_seen;

        // Reset state.
        #12;
        check("rst_outputs", W'({busy, stall, done}), W'(0));
        check("rst_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // flush wins over start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", W'(busy), W'(0));

        run_op("mul_7x6",   3'b000, 32'd7,        32'd6,        32'd42,       35, 1'b1);
        run_op("mul_neg",   3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 35, 1'b0);
        run_op("mulhu",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 1'b0);
        run_op("mulh",      3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35, 1'b0);
        run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 35, 1'b0);
        run_op("mulh_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 35, 1'b0);
        run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35, 1'b0);
        run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35, 1'b0);
        run_op("divu_100",  3'b101, 32'd100,      32'd7,        32'd14,       35, 1'b0);
        run_op("remu_100",  3'b111, 32'd100,      32'd7,        32'd2,        35, 1'b0);
        run_op("divu_big",  3'b101, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        35, 1'b0);
        run_op("divu_z",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  1'b0);
        run_op("rem_z",     3'b110, 32'd5,        32'd0,        32'd5,        2,  1'b0);
        run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  1'b0);
        run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  1'b0);
        run_op("rem_7_m2",  3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        35, 1'b0);
        prior = 32'd1;

        // Flush during ITER counter 10: no done, result unchanged.
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("flush_busy_before", W'({stall, busy}), W'(2'b11));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", W'({stall, busy}), W'(2'b00));
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("flush_no_done", W'(done_seen), W'(0));
        check("flush_result_kept", result, prior);
        run_op("mul_3x3", 3'b000, 32'd3, 32'd3, 32'd9, 35, 1'b0);

        // Async reset at ITER counter 5.
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd1000; op_b = 32'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_outputs", W'({busy, stall, done}), W'(0));
        check("arst_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_divu", 3'b101, 32'd100, 32'd7, 32'd14, 35, 1'b0);

        // Zero-operand multiply (early-out when enabled).
        run_op("mul_zero", 3'b000, 32'd0, 32'd123, 32'd0, EO_LAT, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle controller for the RV32M multiply/divide ops in the pipelined core's execute stage.
- Accepts one op from EX with a start pulse and holds the pipeline via stall while busy.
- Runs a shift-add multiplier or restoring divider, one bit per cycle, and returns a registered result with a one-cycle done pulse.
- Shares a single WIDTH+1-bit adder/subtractor across all ops.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8).
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WIDTH  rs1 value (multiplicand/dividend).
- op_b  input  WIDTH  rs2 value (multiplier/divisor).
- flush  input  1  synchronous abort from hazard unit.
- busy  output  1  high whenever state != IDLE.
- stall  output  1  pipeline hold request.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  final value; held until the next done.

Behaviour:
- Reset (rst_n low, async): state=IDLE, counter=0, busy=0, done=0, stall=0, result=0, all internal regs cleared. A reset mid-operation discards the op.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - On start=1, latch funct3, op_a, op_b, then go to PREP.
  - stall = start (combinational) so EX freezes in the same cycle.
- PREP:
  - Compute operand signs per funct3: MULH both signed; MULHSU op_a signed only; DIV/REM both signed; others unsigned.
  - Take magnitudes, clear accumulator, counter=0, then go to ITER.
  - Special cases go straight to DONE with result loaded:
    - Divide by zero (op_b=0): DIV/DIVU -> all ones; REM/REMU -> op_a.
    - Signed overflow (DIV/REM, op_a=1<<(WIDTH-1), op_b=all ones): DIV -> op_a; REM -> 0.
- ITER: exactly WIDTH cycles, counter 0..WIDTH-1, then go to FIX.
  - Multiply: if multiplier LSB is set, add multiplicand into the high half of a 2*WIDTH product; shift right one bit.
  - Divide: shift remainder:quotient left one bit; trial-subtract divisor with the WIDTH+1-bit adder; on no borrow, keep the difference and set quotient LSB.
- FIX:
  - Negate the 2*WIDTH product if operand signs differ (signed mul ops).
  - Quotient negated if dividend and divisor signs differ. Remainder takes the dividend's sign.
  - Select: MUL = low WIDTH bits; MULH/MULHSU/MULHU = high WIDTH bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register into result, then go to DONE.
- DONE: done=1 for one cycle, stall=0, busy=1, next state IDLE. A start in DONE is ignored; the requester re-asserts it in IDLE.
- stall = 1 in PREP, ITER and FIX.
- Latency: done is high in the (WIDTH+3)th cycle after the start cycle (35 for WIDTH=32). Special cases: done in the 2nd cycle after start.
- flush=1 in any non-IDLE state: next state IDLE, done not raised, result unchanged.
- flush and start both high in IDLE: flush wins; the op is not accepted.
- Operand inputs are ignored after the start cycle; changing them mid-op has no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in PREP, any multiply op with op_a=0 or op_b=0 goes directly to DONE with result=0, giving 2-cycle latency.
- Undefined: all non-special ops take the full WIDTH+3 cycles, and the zero-operand early-out logic is absent.

Test Plan:
- MUL 7 x 6 (WIDTH=32) -> done high exactly 35 cycles after start, result=42; stall high for cycles 0..34, low during done.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> result=0x00000000. MULHSU 0xFFFFFFFF x 2 -> result=0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. Each with done 2 cycles after start.
- Flush at ITER cycle 10 -> state IDLE next cycle, no done pulse, result keeps its prior value. A new MUL 3 x 3 then yields 9 after 35 cycles.
- rst_n low at ITER cycle 5 -> busy/stall/done/result all 0 immediately (async). With MULDIV_EARLY_OUT_EN, MUL 0 x 123 -> result 0, done 2 cycles after start.
